receptor_n_uc: RTL and testbench
================================

// Module: receptor_n_uc
// PURPOSE
//  Generalised multi-byte receive controller: collects NUM_BYTES parity-checked bytes from the serial
//  byte receiver into one word and publishes it atomically. Adds configurable byte order, an inter-byte
//  timeout, error codes and a saturating error counter. Sits between the serial receiver and the
//  consumer logic.
// PARAMETERS
//  BYTE_W      8   width of one received byte
//  NUM_BYTES   2   bytes per word (>=1); IDX_W = max(1,$clog2(NUM_BYTES))
//  MSB_FIRST   0   0: first byte -> dado[BYTE_W-1:0]; 1: first byte -> most-significant slot
//  TIMEOUT     1000  max cycles waiting for next byte mid-word; 0 disables timeout
// PORTS
//  clock           in   1                 system clock, rising edge
//  reset           in   1                 asynchronous, active-low (0 = reset)
//  habilita        in   1                 1 = accept bytes; 0 = idle/abort
//  fim_receber     in   1                 1-cycle pulse: byte_dado/parity_ok valid
//  byte_dado       in   BYTE_W            received byte
//  parity_ok       in   1                 parity check of byte_dado
//  limpa_erros     in   1                 sync clear of contagem_erros
//  dado            out  NUM_BYTES*BYTE_W  last complete word (registered)
//  pronto          out  1                 1-cycle pulse: dado updated
//  erro            out  1                 1-cycle pulse: word discarded
//  erro_codigo     out  2                 00 none, 01 parity, 10 timeout; held until next word completes
//  contagem_erros  out  8                 errors since clear, saturates at 255
//  db_indice       out  IDX_W             byte slot being filled
//  db_estado       out  3                 current state code
// BEHAVIOUR
//  Reset: state ESPERA, dado=0, pronto=0, erro=0, erro_codigo=00, contagem_erros=0, index=0,
//    timeout counter=0, internal buffer=0.
//  States: ESPERA=0, CARREGA=1, FIM=2, ERRO=3; codes 4-7 illegal -> ESPERA.
//  ESPERA: if habilita=0: stay, index<=0, timer<=0 (silent abort, no erro).
//    elif fim_receber: parity_ok=1 -> byte_dado captured to holding reg, go CARREGA;
//      parity_ok=0 -> erro_codigo<=01, go ERRO.
//    elif index>0 and TIMEOUT>0 and timer==TIMEOUT-1 -> erro_codigo<=10, go ERRO.
//    else timer increments while index>0; timer held at 0 while index==0.
//  CARREGA: holding reg -> slot index (slot=index, or NUM_BYTES-1-index if MSB_FIRST); timer<=0.
//    index==NUM_BYTES-1 -> go FIM, and on the same edge dado<=buffer with this byte merged;
//    else index<=index+1, go ESPERA.
//  FIM: pronto=1 (one cycle), erro_codigo<=00, index<=0, go ESPERA.
//  ERRO: erro=1 (one cycle), contagem_erros+1 unless 255, index<=0, timer<=0, partial buffer discarded;
//    dado unchanged; go ESPERA.
//  pronto/erro are Moore decodes of state; never both 1.
//  Latency: last byte's fim_receber at edge N -> CARREGA at N+1 -> dado valid and pronto=1 from N+2.
//  fim_receber in CARREGA/FIM/ERRO is ignored (byte lost; upstream guarantees >=3 cycle spacing).
//  limpa_erros has priority over increment in the same cycle (result 0).
//  NUM_BYTES=1: every good byte goes ESPERA->CARREGA->FIM; timeout never fires.
//  Reset asserted mid-word: immediate return to reset values; dado cleared.
// TESTING
//  NUM_BYTES=2, MSB_FIRST=0: bytes 0x34,0x12 good -> dado=0x1234, single pronto pulse, erro never 1.
//  MSB_FIRST=1, NUM_BYTES=4: 0xDE,0xAD,0xBE,0xEF -> dado=0xDEADBEEF, db_indice walks 0..3.
//  2nd byte with parity_ok=0 -> erro pulse, erro_codigo=01, contagem_erros=1, dado keeps prior word.
//  TIMEOUT=10: one byte then silence -> erro 11 cycles after first CARREGA, erro_codigo=10; next word OK.
//  habilita dropped after 1st byte, then 2 good bytes -> word built from new bytes only, no erro.
//  Force 256 parity errors -> contagem_erros=255; limpa_erros with error same cycle -> 0.

Source files
------------

// File: rtl/receptor_n_uc.sv
// Multi-byte receive controller: gathers NUM_BYTES parity-checked bytes from
// the serial byte receiver and publishes them as one word in a single update.
// It supports either byte order, an inter-byte timeout, error codes and a
// saturating error counter.
module receptor_n_uc #(
  parameter  int BYTE_W    = 8,
  parameter  int NUM_BYTES = 2,
  parameter  int MSB_FIRST = 0,
  parameter  int TIMEOUT   = 1000,
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          habilita,
  input  logic                          fim_receber,
  input  logic [BYTE_W-1:0]             byte_dado,
  input  logic                          parity_ok,
  input  logic                          limpa_erros,
  output logic [NUM_BYTES*BYTE_W-1:0]   dado,
  output logic                          pronto,
  output logic                          erro,
  output logic [1:0]                    erro_codigo,
  output logic [7:0]                    contagem_erros,
  output logic [IDX_W-1:0]              db_indice,
  output logic [2:0]                    db_estado
);

  // The timer only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BYTES - 1);
  localparam int WORD_W = NUM_BYTES * BYTE_W;

  typedef enum logic [2:0] {
    ESPERA  = 3'd0,
    CARREGA = 3'd1,
    FIM     = 3'd2,
    ERRO    = 3'd3
  } estado_t;

  estado_t            state, state_next;
  logic [IDX_W-1:0]   index;
  logic [TMR_W-1:0]   timer;
  logic [BYTE_W-1:0]  hold;
  logic [WORD_W-1:0]  buffer;
  logic [WORD_W-1:0]  merged;
  logic [IDX_W-1:0]   slot;
  logic               timeout_hit;

  // Timeout only matters once a word is partly built; with a single byte per
  // word the index never leaves 0, so it can never fire.
  assign timeout_hit = (TIMEOUT > 0) && (index != '0) && (timer == TMR_LAST);

  // Byte order chooses which slot the current byte lands in.
  assign slot = (MSB_FIRST != 0) ? (IDX_LAST - index) : index;

  // Partial buffer with the held byte merged into its slot; this is both the
  // next buffer value and, on the last byte, the published word.
  generate
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_merge
      assign merged[gi*BYTE_W +: BYTE_W] =
        (slot == IDX_W'(gi)) ? hold : buffer[gi*BYTE_W +: BYTE_W];
    end
  endgenerate

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ESPERA;
    else        state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = ESPERA;
    case (state)
      ESPERA: begin
        state_next = ESPERA;
        if (habilita) begin
          if (fim_receber)      state_next = parity_ok ? CARREGA : ERRO;
          else if (timeout_hit) state_next = ERRO;
        end
      end
      CARREGA: state_next = (index == IDX_LAST) ? FIM : ESPERA;
      FIM:     state_next = ESPERA;
      ERRO:    state_next = ESPERA;
      default: state_next = ESPERA;
    endcase
  end

  // Datapath: byte capture, slot index, inter-byte timer, word publish, error code.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      index       <= '0;
      timer       <= '0;
      hold        <= '0;
      buffer      <= '0;
      dado        <= '0;
      erro_codigo <= 2'b00;
    end else begin
      case (state)
        ESPERA: begin
          if (!habilita) begin
            index <= '0;
            timer <= '0;
          end else if (fim_receber) begin
            if (parity_ok) hold <= byte_dado;
            else           erro_codigo <= 2'b01;
          end else if (timeout_hit) begin
            erro_codigo <= 2'b10;
          end else if (index != '0 && TIMEOUT > 0) begin
            timer <= timer + TMR_W'(1);
          end else begin
            timer <= '0;
          end
        end
        CARREGA: begin
          buffer <= merged;
          timer  <= '0;
          if (index == IDX_LAST) dado  <= merged;
          else                   index <= index + IDX_W'(1);
        end
        FIM: begin
          erro_codigo <= 2'b00;
          index       <= '0;
        end
        ERRO: begin
          index  <= '0;
          timer  <= '0;
          buffer <= '0;
        end
        default: begin
          index <= '0;
          timer <= '0;
        end
      endcase
    end
  end

  // Saturating error counter; a clear wins over a same-cycle increment.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                   contagem_erros <= 8'd0;
    else if (limpa_erros)                         contagem_erros <= 8'd0;
    else if (state == ERRO && contagem_erros != 8'hFF) contagem_erros <= contagem_erros + 8'd1;
  end

  assign pronto    = (state == FIM);
  assign erro      = (state == ERRO);
  assign db_indice = index;
  assign db_estado = state;

endmodule

// File: tb/tb_receptor_n_uc.sv
// Directed bench for receptor_n_uc: a 2-byte LSB-first instance with a short
// timeout and a 4-byte MSB-first instance, sharing the byte stream.
module tb_receptor_n_uc;

  logic        clock;
  logic        reset;
  logic        habilita_a, habilita_b;
  logic        fim_receber;
  logic [7:0]  byte_dado;
  logic        parity_ok;
  logic        limpa_erros;

  logic [15:0] dado_a;
  logic        pronto_a, erro_a;
  logic [1:0]  codigo_a;
  logic [7:0]  cont_a;
  logic [0:0]  indice_a;
  logic [2:0]  estado_a;

  logic [31:0] dado_b;
  logic        pronto_b, erro_b;
  logic [1:0]  codigo_b;
  logic [7:0]  cont_b;
  logic [1:0]  indice_b;
  logic [2:0]  estado_b;

  int total = 0;
  int bad   = 0;
  int n_pronto_a = 0;
  int n_erro_a   = 0;

  receptor_n_uc #(.BYTE_W(8), .NUM_BYTES(2), .MSB_FIRST(0), .TIMEOUT(10)) dut_a (
    .clock(clock), .reset(reset), .habilita(habilita_a), .fim_receber(fim_receber),
    .byte_dado(byte_dado), .parity_ok(parity_ok), .limpa_erros(limpa_erros),
    .dado(dado_a), .pronto(pronto_a), .erro(erro_a), .erro_codigo(codigo_a),
    .contagem_erros(cont_a), .db_indice(indice_a), .db_estado(estado_a)
  );

  receptor_n_uc #(.BYTE_W(8), .NUM_BYTES(4), .MSB_FIRST(1), .TIMEOUT(1000)) dut_b (
    .clock(clock), .reset(reset), .habilita(habilita_b), .fim_receber(fim_receber),
    .byte_dado(byte_dado), .parity_ok(parity_ok), .limpa_erros(limpa_erros),
    .dado(dado_b), .pronto(pronto_b), .erro(erro_b), .erro_codigo(codigo_b),
    .contagem_erros(cont_b), .db_indice(indice_b), .db_estado(estado_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count output pulses of instance A so pulse uniqueness can be checked.
  always @(negedge clock) begin
    if (pronto_a) n_pronto_a++;
    if (erro_a)   n_erro_a++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called 1ns after an edge; the pulse is sampled on the next edge.
  task automatic send(input logic [7:0] b, input logic par);
    $display("rx byte=%h parity_ok=%b t=%0t", b, par, $time);
    byte_dado   = b;
    parity_ok   = par;
    fim_receber = 1'b1;
    @(posedge clock); #1;
    fim_receber = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; habilita_a = 1'b1; habilita_b = 1'b0;
    fim_receber = 1'b0; byte_dado = 8'h00; parity_ok = 1'b1; limpa_erros = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_dado",   32'(dado_a),   32'h0);
    chk("rst_pronto", 32'(pronto_a), 32'h0);
    chk("rst_erro",   32'(erro_a),   32'h0);
    chk("rst_codigo", 32'(codigo_a), 32'h0);
    chk("rst_cont",   32'(cont_a),   32'h0);
    chk("rst_indice", 32'(indice_a), 32'h0);
    chk("rst_estado", 32'(estado_a), 32'h0);
    reset = 1'b1;
    wait_cyc(1);

    // Two good bytes, LSB first, with exact publish latency.
    send(8'h34, 1'b1); wait_cyc(2);
    chk("a_idx1", 32'(indice_a), 32'h1);
    send(8'h12, 1'b1);
    chk("a_carrega", 32'(estado_a), 32'h1);
    chk("a_no_pronto_early", 32'(pronto_a), 32'h0);
    wait_cyc(1);
    chk("a_fim_estado", 32'(estado_a), 32'h2);
    chk("a_pronto", 32'(pronto_a), 32'h1);
    chk("a_dado", 32'(dado_a), 32'h1234);
    wait_cyc(1);
    chk("a_pronto_off", 32'(pronto_a), 32'h0);
    chk("a_idx0", 32'(indice_a), 32'h0);
    chk("a_pronto_cnt", 32'(n_pronto_a), 32'h1);
    chk("a_erro_cnt", 32'(n_erro_a), 32'h0);

    // Parity error on the second byte.
    send(8'h55, 1'b1); wait_cyc(2);
    send(8'h66, 1'b0);
    chk("par_estado", 32'(estado_a), 32'h3);
    chk("par_erro", 32'(erro_a), 32'h1);
    chk("par_codigo", 32'(codigo_a), 32'h1);
    wait_cyc(1);
    chk("par_erro_off", 32'(erro_a), 32'h0);
    chk("par_cont", 32'(cont_a), 32'h1);
    chk("par_dado_kept", 32'(dado_a), 32'h1234);
    chk("par_idx0", 32'(indice_a), 32'h0);

    // Timeout: one byte then silence; erro lands 11 cycles after CARREGA.
    send(8'h77, 1'b1);
    wait_cyc(10);
    chk("to_not_yet", 32'(erro_a), 32'h0);
    chk("to_codigo_held", 32'(codigo_a), 32'h1);
    wait_cyc(1);
    chk("to_erro", 32'(erro_a), 32'h1);
    chk("to_codigo", 32'(codigo_a), 32'h2);
    wait_cyc(1);
    chk("to_cont", 32'(cont_a), 32'h2);
    send(8'hCD, 1'b1); wait_cyc(2);
    send(8'hAB, 1'b1); wait_cyc(1);
    chk("to_next_dado", 32'(dado_a), 32'hABCD);
    chk("to_next_pronto", 32'(pronto_a), 32'h1);
    wait_cyc(1);
    chk("to_codigo_clr", 32'(codigo_a), 32'h0);

    // Abort by dropping habilita after the first byte.
    send(8'h11, 1'b1); wait_cyc(2);
    habilita_a = 1'b0; wait_cyc(2);
    chk("ab_idx0", 32'(indice_a), 32'h0);
    habilita_a = 1'b1;
    send(8'h22, 1'b1); wait_cyc(2);
    send(8'h33, 1'b1); wait_cyc(1);
    chk("ab_dado", 32'(dado_a), 32'h3322);
    wait_cyc(1);
    chk("ab_erro_cnt", 32'(n_erro_a), 32'h2);
    chk("ab_pronto_cnt", 32'(n_pronto_a), 32'h3);
    chk("ab_cont", 32'(cont_a), 32'h2);

    // Saturation, then a clear in the same cycle as an increment.
    for (int i = 0; i < 256; i++) begin
      send(8'hF0, 1'b0); wait_cyc(2);
    end
    chk("sat_cont", 32'(cont_a), 32'hFF);
    chk("sat_dado_kept", 32'(dado_a), 32'h3322);
    send(8'hF1, 1'b0);
    limpa_erros = 1'b1;
    wait_cyc(1);
    limpa_erros = 1'b0;
    chk("clr_priority", 32'(cont_a), 32'h0);
    wait_cyc(1);

    // Reset mid-word clears everything immediately.
    send(8'h44, 1'b1); wait_cyc(2);
    chk("mid_idx1", 32'(indice_a), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_dado", 32'(dado_a), 32'h0);
    chk("mid_rst_idx", 32'(indice_a), 32'h0);
    chk("mid_rst_estado", 32'(estado_a), 32'h0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Four bytes, MSB first, on instance B.
    habilita_a = 1'b0;
    habilita_b = 1'b1;
    chk("b_idx0", 32'(indice_b), 32'h0);
    send(8'hDE, 1'b1); wait_cyc(2);
    chk("b_idx1", 32'(indice_b), 32'h1);
    send(8'hAD, 1'b1); wait_cyc(2);
    chk("b_idx2", 32'(indice_b), 32'h2);
    send(8'hBE, 1'b1); wait_cyc(2);
    chk("b_idx3", 32'(indice_b), 32'h3);
    send(8'hEF, 1'b1); wait_cyc(1);
    chk("b_estado", 32'(estado_b), 32'h2);
    chk("b_pronto", 32'(pronto_b), 32'h1);
    chk("b_dado", dado_b, 32'hDEADBEEF);
    chk("b_erro", 32'(erro_b), 32'h0);
    wait_cyc(1);
    chk("b_idx_back0", 32'(indice_b), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
